// File: rtl/axi_mem_rsp.sv
// AXI4 read-burst responder (FIXED/INCR/WRAP) over a memory with one cycle of read latency.
// Optional AXI_RSP_LAT_EN: inserts FIRST_LAT wait cycles (WAIT state) before the first beat.
module axi_mem_rsp #(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          FIRST_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;
    state_t state;

    logic [31:0] addr_p0;
    logic [31:0] start_addr, wrap_mask, step;
    logic [31:0] next_addr, size_mask, wrap_m;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic        err, ar_err;
    logic [8:0]  issue_cnt;
    logic [7:0]  beat_cnt;
    logic        vld_p1;
    logic [63:0] buf_data [2];
    logic        buf_wr, buf_rd;
    logic [1:0]  buf_cnt;
    logic        ar_hs, r_hs, push, pop_buf;
`ifdef AXI_RSP_LAT_EN
    logic [15:0] lat_cnt;
`endif

    // Request decode: legality check and wrap window for the incoming burst.
    always_comb begin
        size_mask = (32'd1 << arsize) - 32'd1;
        wrap_m    = (({24'd0, arlen} + 32'd1) << arsize) - 32'd1;
        ar_err    = (arburst == 2'b11) || (arsize > 3'd3) || (araddr < BASE)
                 || (arburst == 2'b10 && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                 || (arburst != 2'b00 && (araddr & size_mask) != 32'd0);
    end

    always_comb begin
        case (burst)
            2'b01:   next_addr = addr_p0 + step;
            2'b10:   next_addr = (start_addr & ~wrap_mask) | ((addr_p0 + step) & wrap_mask);
            default: next_addr = addr_p0;
        endcase
    end

    assign arready  = rst && (state == IDLE);
    assign ar_hs    = arvalid && (state == IDLE);
    // A read may only be issued when the buffer can absorb it even if nothing drains.
    assign mem_ren  = (state == STREAM) && !err && (issue_cnt <= {1'b0, len})
                   && (({1'b0, buf_cnt} + {2'b00, vld_p1}) < 3'd2);
    assign mem_addr = mem_ren ? {addr_p0[31:3], 3'b000} : 32'd0;

    // Output stage: buffer head first, else memory data bypassed straight through.
    always_comb begin
        rvalid = 1'b0;
        rdata  = 64'd0;
        rresp  = 2'b00;
        if (state == STREAM) begin
            if (err) begin
                rvalid = 1'b1;
                rresp  = 2'b10;
            end else if (buf_cnt != 2'd0) begin
                rvalid = 1'b1;
                rdata  = buf_data[buf_rd];
            end else if (vld_p1) begin
                rvalid = 1'b1;
                rdata  = mem_rdata;
            end
        end
        rlast = rvalid && (beat_cnt == len);
    end

    assign r_hs    = rvalid && rready;
    assign pop_buf = r_hs && (buf_cnt != 2'd0);
    assign push    = vld_p1 && !(buf_cnt == 2'd0 && rready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            err       <= 1'b0;
            vld_p1    <= 1'b0;
            buf_cnt   <= 2'd0;
            buf_wr    <= 1'b0;
            buf_rd    <= 1'b0;
            issue_cnt <= 9'd0;
            beat_cnt  <= 8'd0;
`ifdef AXI_RSP_LAT_EN
            lat_cnt   <= 16'd0;
`endif
        end else begin
            vld_p1  <= mem_ren;
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop_buf};
            if (push)    buf_wr <= ~buf_wr;
            if (pop_buf) buf_rd <= ~buf_rd;
            if (mem_ren) issue_cnt <= issue_cnt + 9'd1;
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        err       <= ar_err;
                        issue_cnt <= 9'd0;
                        beat_cnt  <= 8'd0;
`ifdef AXI_RSP_LAT_EN
                        if (FIRST_LAT == 0) begin
                            state <= STREAM;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 16'(FIRST_LAT - 1);
                        end
`else
                        state <= STREAM;
`endif
                    end
                end
                WAIT: begin
`ifdef AXI_RSP_LAT_EN
                    if (lat_cnt == 16'd0) state <= STREAM;
                    else                  lat_cnt <= lat_cnt - 16'd1;
`else
                    state <= IDLE;
`endif
                end
                STREAM: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (rlast) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Burst descriptor and read-data buffer; contents are don't-care until qualified.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            addr_p0    <= araddr;
            start_addr <= araddr;
            wrap_mask  <= wrap_m;
            step       <= 32'd1 << arsize;
            burst      <= arburst;
            len        <= arlen;
        end else if (mem_ren) begin
            addr_p0 <= next_addr;
        end
        if (push) buf_data[buf_wr] <= mem_rdata;
    end
endmodule

// File: doc/axi_mem_rsp.md
# axi_mem_rsp

AXI4 read-channel responder serving burst reads from a synchronous backing memory. It is the slave-side counterpart of the instruction-cache refill master in the fetch stage, and sits between the core's AR/R bus and the simulation/SoC memory. It accepts one read burst at a time, generates the beat addresses for FIXED, INCR or WRAP bursts, and streams the beats back under `rready` backpressure at up to one beat per cycle.

## Interface
Parameters:
- `BASE`, 32'h8000_0000: lowest legal byte address; any lower address is an error.
- `FIRST_LAT`, 4: extra wait cycles before the first beat; used only when `AXI_RSP_LAT_EN` is defined.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `araddr`  in  32  burst start byte address.
- `arvalid`  in  1  AR request valid.
- `arburst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `arlen`  in  8  beats minus 1.
- `arsize`  in  3  log2 of bytes per beat.
- `arready`  out  1  AR accept.
- `rdata`  out  64  beat data.
- `rresp`  out  2  00 OKAY, 10 SLVERR.
- `rvalid`  out  1  R beat valid.
- `rlast`  out  1  final beat of the burst.
- `rready`  in  1  master accepts the beat.
- `mem_ren`  out  1  memory read strobe.
- `mem_addr`  out  32  8-byte-aligned word address (`beat_addr & ~7`).
- `mem_rdata`  in  64  memory data, valid the cycle after `mem_ren`.

## Operation
- FSM states: IDLE, WAIT, STREAM. Reset state is IDLE.
- IDLE: `arready`=1. On `arvalid&arready`, latch addr/burst/len/size, clear the beat counter, compute `err`, and go to WAIT if the latency option is compiled in, otherwise to STREAM.
- `err` is set for any of these: `arburst`=11; `arsize`>3; `araddr`<`BASE`; WRAP with `arlen` not in {1,3,7,15}; WRAP or INCR with `araddr` not aligned to `1<<arsize`.
- WAIT: count down `FIRST_LAT` cycles, then go to STREAM.
- STREAM: issue `mem_ren` for the next beat address whenever the 2-entry output buffer has room after in-flight reads are counted. Returned data is pushed into the buffer. The buffer head drives `rdata`/`rresp`/`rlast`/`rvalid`.
- Beat address generation:
  - FIXED: the address stays constant.
  - INCR: add `1<<arsize`, no 4 KB boundary check.
  - WRAP: the boundary size is `(arlen+1)<<arsize`. The next address is `base_lo | ((addr+step) & (size-1))`, where `base_lo = start & ~(size-1)`.
- Narrow beats return the full 64-bit word; the byte lanes follow the address.
- Error bursts: still return exactly `arlen+1` beats, each with `rresp`=10 and `rdata`=0, and `mem_ren` is never asserted.
- `rlast`=1 only on beat index `arlen`. After the `rlast` handshake, go to IDLE.
- `rresp` is 00 on all non-error beats.

## Timing
- Reset (`rst`=0): asynchronously forces state IDLE, buffer empty, counters 0. Outputs during reset: `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=00, `rdata`=0, `mem_ren`=0, `mem_addr`=0.
- Reset asserted mid-burst drops the burst; no further beats are emitted. `arready`=1 in the first cycle after reset is released.
- First beat latency, without the option: AR handshake at edge k, `mem_ren` in cycle k+1, `rvalid` in cycle k+2. Error bursts present `rvalid` at k+1.
- Steady state with `rready`=1: one beat per cycle and no bubbles.
- Backpressure with `rready`=0:
  - `rvalid`, `rdata`, `rresp` and `rlast` hold stable until the handshake.
  - `mem_ren` stops when the buffer plus in-flight reads reach 2.
  - No beat is ever lost or duplicated.
- Back-to-back bursts: `arready` rises in the cycle after the `rlast` handshake. A new AR can therefore be accepted no sooner than 1 cycle after the last beat.
- Memory read and buffer push/pop in the same cycle are legal and keep the occupancy constant.

## Configuration
- `AXI_RSP_LAT_EN` defined: WAIT state is present. The first beat appears `FIRST_LAT` cycles later than the no-option timing, for both normal and error bursts. `FIRST_LAT`=0 behaves like the no-option case.
- `AXI_RSP_LAT_EN` undefined: WAIT state and its counter are not synthesized, and IDLE goes directly to STREAM.

## Test plan
- INCR burst `araddr`=0x8000_0000, `arlen`=1, `arsize`=3, `rready`=1 → `mem_addr` takes 0x8000_0000 then 0x8000_0008. Beats arrive at k+2 and k+3, `rlast` is on the 2nd beat, `rresp`=00.
- WRAP burst `araddr`=0x8000_0018, `arlen`=3, `arsize`=3 → `mem_addr` sequence 0x18, 0x00, 0x08, 0x10 (offsets from 0x8000_0000), with `rlast` on the 4th beat.
- INCR `arlen`=7 with `rready` toggling 1,0,0,1 → all 8 words arrive in order, each held stable while stalled. Outstanding reads never exceed 2.
- Error burst `araddr`=0x7FFF_FFF0, `arlen`=2 → 3 beats with `rresp`=10 and `rdata`=0, `rlast` on the 3rd beat, `mem_ren` never asserted. The same applies to `arburst`=11.
- `rst` pulled low during beat 3 of an `arlen`=7 burst → `rvalid`=0 immediately. After release, `arready`=1, and a new burst completes normally.
- With `AXI_RSP_LAT_EN` and `FIRST_LAT`=4 → first `rvalid` at k+6 and `mem_ren` at k+5.
